// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// The mult/div busy counter is only built when PIPE_CTRL_MDU_EN is defined.
package pipe_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [3:0] MULT_CYC  = 4'd5;
    localparam logic [3:0] DIV_CYC   = 4'd10;
    localparam int         SLOT_W    = 7;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } sb_slot_t;

    function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
    endfunction

    // Register 0 never stalls: src must be nonzero, so it can never match a null dst.
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input sb_slot_t e, input sb_slot_t m);
        return (src != 5'd0) && (tuse != TUSE_NONE) &&
               (((e.dst == src) && (e.tnew > tuse)) || ((m.dst == src) && (m.tnew > tuse)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode-stage hazard bus between the pipeline datapath and pipe_ctrl.
interface pipe_ctrl_if;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_rs_tuse;
    logic [1:0] D_rt_tuse;
    logic [4:0] D_dst;
    logic [1:0] D_tnew;
    logic       D_is_md;
    logic       E_md_start;
    logic       E_md_div;
    logic       Req;
    logic       stall;
    logic       D_WE;
    logic       E_clr;
    logic       md_busy;

    modport master (
        output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_dst, D_tnew, D_is_md,
               E_md_start, E_md_div, Req,
        input  stall, D_WE, E_clr, md_busy
    );

    modport slave (
        input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_dst, D_tnew, D_is_md,
               E_md_start, E_md_div, Req,
        output stall, D_WE, E_clr, md_busy
    );
endinterface

// File: rtl/pipe_md_cnt.sv
// Mult/div busy counter: loads the unit latency on an issue, then counts down to 0.
module pipe_md_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic div_i,
    input  logic req_i,
    output logic busy_o
);

    logic [3:0] md_cnt_q, md_cnt_d;
    logic       start_ok;

    // An issue coinciding with a flush is dropped; a running count keeps going.
    assign start_ok = start_i & ~req_i;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (start_ok)
            md_cnt_d = div_i ? DIV_CYC : MULT_CYC;
        else if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            md_cnt_q <= 4'd0;
        else
            md_cnt_q <= md_cnt_d;
    end

    assign busy_o = (md_cnt_q != 4'd0) | start_ok;

endmodule

// File: rtl/pipe_ctrl.sv
// Decode-stage hazard controller: 2-slot result scoreboard plus optional mult/div busy stall.
// Optional feature macro: PIPE_CTRL_MDU_EN (mult/div busy counter and stall).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    sb_slot_t slot_e_q, slot_e_d;
    sb_slot_t slot_m_q, slot_m_d;
    logic     hazard;
    logic     md_busy;
    logic     stall;

`ifdef PIPE_CTRL_MDU_EN
    pipe_md_cnt u_md_cnt (
        .clk     (clk),
        .rst     (rst),
        .start_i (bus.E_md_start),
        .div_i   (bus.E_md_div),
        .req_i   (bus.Req),
        .busy_o  (md_busy)
    );
`else
    logic md_inputs_unused;
    assign md_inputs_unused = bus.E_md_start ^ bus.E_md_div;
    assign md_busy = 1'b0;
`endif

    assign hazard = src_hazard(bus.D_rs, bus.D_rs_tuse, slot_e_q, slot_m_q) |
                    src_hazard(bus.D_rt, bus.D_rt_tuse, slot_e_q, slot_m_q);

    assign stall = hazard | (bus.D_is_md & md_busy);

    // Req wins over stall for the slots; a stalled D instruction enters E as a bubble.
    always_comb begin
        slot_e_d = '0;
        if (!bus.Req && !stall)
            slot_e_d = '{dst: bus.D_dst, tnew: bus.D_tnew};
        slot_m_d = '0;
        if (!bus.Req)
            slot_m_d = '{dst: slot_e_q.dst, tnew: tnew_dec(slot_e_q.tnew)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_e_q <= '0;
            slot_m_q <= '0;
        end else begin
            slot_e_q <= slot_e_d;
            slot_m_q <= slot_m_d;
        end
    end

    assign bus.stall   = stall;
    assign bus.D_WE    = ~stall;
    assign bus.E_clr   = stall | bus.Req;
    assign bus.md_busy = md_busy;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed decode-stage sequences with an expected-output queue.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_MDU_EN
    localparam logic MDU = 1'b1;
`else
    localparam logic MDU = 1'b0;
`endif

    typedef struct {
        string tag;
        logic  stall;
        logic  dwe;
        logic  eclr;
        logic  busy;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [1:0] rs_tuse,
                         input logic [4:0] rt, input logic [1:0] rt_tuse,
                         input logic [4:0] dst, input logic [1:0] tnew, input logic is_md,
                         input logic start, input logic div, input logic req, input logic rst_v);
        bus.D_rs       = rs;
        bus.D_rs_tuse  = rs_tuse;
        bus.D_rt       = rt;
        bus.D_rt_tuse  = rt_tuse;
        bus.D_dst      = dst;
        bus.D_tnew     = tnew;
        bus.D_is_md    = is_md;
        bus.E_md_start = start;
        bus.E_md_div   = div;
        bus.Req        = req;
        rst            = rst_v;
    endtask

    // One decode cycle: drive inputs, queue the expected outputs, compare just after settling.
    task automatic step(input string tag,
                        input logic [4:0] rs, input logic [1:0] rs_tuse,
                        input logic [4:0] rt, input logic [1:0] rt_tuse,
                        input logic [4:0] dst, input logic [1:0] tnew, input logic is_md,
                        input logic start, input logic div, input logic req, input logic rst_v,
                        input logic exp_stall, input logic exp_busy);
        exp_t e;
        @(negedge clk);
        drive(rs, rs_tuse, rt, rt_tuse, dst, tnew, is_md, start, div, req, rst_v);
        e.tag   = tag;
        e.stall = exp_stall;
        e.dwe   = ~exp_stall;
        e.eclr  = exp_stall | req;
        e.busy  = exp_busy;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".stall"},   {7'd0, bus.stall},   {7'd0, e.stall});
        check({e.tag, ".D_WE"},    {7'd0, bus.D_WE},    {7'd0, e.dwe});
        check({e.tag, ".E_clr"},   {7'd0, bus.E_clr},   {7'd0, e.eclr});
        check({e.tag, ".md_busy"}, {7'd0, bus.md_busy}, {7'd0, e.busy});
    endtask

    task automatic nop(input string tag, input logic req, input logic exp_busy);
        step(tag, 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0, 1'b0,
             1'b0, 1'b0, req, 1'b0, 1'b0, exp_busy);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);

        nop("rst_req", 1'b1, 1'b0);
        nop("rst_idle", 1'b0, 1'b0);

        // lw $8 then dependent addu: one stall cycle
        step("lw8",     0, TUSE_NONE, 0, TUSE_NONE, 8, 2, 0, 0, 0, 0, 0, 0, 0);
        step("addu_s",  8, 2'd1,      8, 2'd1,      9, 1, 0, 0, 0, 0, 0, 1, 0);
        step("addu_go", 8, 2'd1,      8, 2'd1,      9, 1, 0, 0, 0, 0, 0, 0, 0);
        nop("nop_a", 1'b0, 1'b0);

        // register 0 destination never stalls
        step("dst0",    0, TUSE_NONE, 0, TUSE_NONE, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        step("rs0",     0, 2'd0,      0, TUSE_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // rt hazard against slot M
        step("lw4",     0, TUSE_NONE, 0, TUSE_NONE, 4, 2, 0, 0, 0, 0, 0, 0, 0);
        nop("nop_b", 1'b0, 1'b0);
        step("rt_m_s",  0, TUSE_NONE, 4, 2'd0,      0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("rt_m_go", 0, TUSE_NONE, 4, 2'd0,      0, 0, 0, 0, 0, 0, 0, 0, 0);

        // unused operand and tuse == tnew do not stall
        step("lw5",     0, TUSE_NONE, 0, TUSE_NONE, 5, 2, 0, 0, 0, 0, 0, 0, 0);
        step("tuse_eq", 5, TUSE_NONE, 5, 2'd2,      0, 0, 0, 0, 0, 0, 0, 0, 0);

        // div issue with mflo behind it: 10 busy cycles after the issue cycle
        step("div_iss", 0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 1, 1, 0, 0, MDU, MDU);
        for (int i = 0; i < 10; i++)
            step($sformatf("div_w%0d", i), 0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 0, 0, 0, 0, MDU, MDU);
        step("div_done", 0, TUSE_NONE, 0, TUSE_NONE, 6, 2, 1, 0, 0, 0, 0, 0, 0);

        // Req with mult issue: start dropped, both slots flushed
        step("req_mult", 0, TUSE_NONE, 0, TUSE_NONE, 6, 2, 0, 1, 0, 1, 0, 0, 0);
        step("req_clr",  6, 2'd0,      6, 2'd0,      0, 0, 1, 0, 0, 0, 0, 0, 0);

        // mult latency with a Req in the middle that must not stop the count
        step("mul_iss", 0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 0, 1, 0, 0, 0, 0, MDU);
        step("mul_w0",  0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 0, 0, 0, 0, MDU, MDU);
        step("mul_w1",  0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 0, 0, 1, 0, MDU, MDU);
        for (int i = 2; i < 5; i++)
            step($sformatf("mul_w%0d", i), 0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 0, 0, 0, 0, MDU, MDU);
        step("mul_done", 0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // reset with md_cnt=7 and slot E={5,2}; rst beats Req and a new issue
        step("div2_iss", 0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 0, 1, 1, 0, 0, 0, MDU);
        nop("div2_n0", 1'b0, MDU);
        nop("div2_n1", 1'b0, MDU);
        step("ld5_e",   0, TUSE_NONE, 0, TUSE_NONE, 5, 2, 0, 0, 0, 0, 0, 0, MDU);
        step("rst_hit", 5, 2'd0,      0, TUSE_NONE, 0, 0, 1, 1, 0, 1, 1, 1, MDU);
        step("rst_aft", 5, 2'd0,      0, TUSE_NONE, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
